// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: word/line/offset geometry and the line reader state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;
  typedef logic [2:0]   lc3b_c_offset;

  localparam int unsigned LC3B_C_WORDS = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } lc3b_lr_state_t;

endpackage

// File: rtl/line_reader_if.sv
// Load-side and word-side handshake bundle of the line reader.
interface line_reader_if;
  import lc3b_types::*;

  lc3b_c_line   line_in;
  lc3b_c_offset start_offset;
  logic         load_valid;
  logic         load_ready;
  logic         abort;
  lc3b_word     word_out;
  lc3b_c_offset word_offset;
  logic         word_valid;
  logic         word_ready;
  logic         word_last;
  logic         busy;

  // Producer of lines and consumer of words.
  modport master (
    output line_in, start_offset, load_valid, abort, word_ready,
    input  load_ready, word_out, word_offset, word_valid, word_last, busy
  );

  modport slave (
    input  line_in, start_offset, load_valid, abort, word_ready,
    output load_ready, word_out, word_offset, word_valid, word_last, busy
  );

endinterface

// File: rtl/line_word_select.sv
// Combinational word mux: picks word `offset_i` out of a cache line.
module line_word_select
  import lc3b_types::*;
(
  input  lc3b_c_line   line_i,
  input  lc3b_c_offset offset_i,
  output lc3b_word     word_o
);

  assign word_o = line_i[{offset_i, 4'b0000} +: 16];

endmodule

// File: rtl/line_reader.sv
// Streams a 128-bit line as eight 16-bit words, critical word first, wrapping modulo 8.
module line_reader
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  line_reader_if.slave  bus
);

  localparam lc3b_c_offset LastCnt = 3'(LC3B_C_WORDS - 1);

  lc3b_lr_state_t state_q;
  lc3b_c_line     line_q;
  lc3b_c_offset   ptr_q;
  logic [2:0]     cnt_q;

  logic cnt_last;
  logic load_ready;
  logic load;

  assign cnt_last = (cnt_q == LastCnt);

  // Accepting during the last beat lets consecutive lines stream without a bubble.
  assign load_ready = !bus.abort &&
                      ((state_q == IDLE) || ((state_q == SEND) && cnt_last && bus.word_ready));
  assign load       = bus.load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else if (bus.abort) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            line_q  <= bus.line_in;
            ptr_q   <= bus.start_offset;
            cnt_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (bus.word_ready) begin
            if (!cnt_last) begin
              ptr_q <= ptr_q + 3'd1;
              cnt_q <= cnt_q + 3'd1;
            end else if (load) begin
              line_q <= bus.line_in;
              ptr_q  <= bus.start_offset;
              cnt_q  <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  line_word_select u_sel (
    .line_i   (line_q),
    .offset_i (ptr_q),
    .word_o   (bus.word_out)
  );

  assign bus.load_ready  = load_ready;
  assign bus.word_offset = ptr_q;
  assign bus.word_valid  = (state_q == SEND);
  assign bus.word_last   = (state_q == SEND) && cnt_last;
  assign bus.busy        = (state_q == SEND);

endmodule

// File: tb/tb_line_reader.sv
// Self-checking bench for line_reader: directed scenarios plus randomized traffic vs a queue model.
module tb_line_reader;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  line_reader_if bus ();

  line_reader u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0]  o;
    logic [15:0] w;
  } beat_t;

  // Model: the words still owed to the consumer, in delivery order.
  beat_t exp_q[$];
  int total = 0;
  int bad = 0;
  logic [127:0] line_a, line_b;

  function automatic logic exp_valid();
    return exp_q.size() > 0;
  endfunction

  function automatic logic exp_last();
    return exp_q.size() == 1;
  endfunction

  function automatic logic exp_lr();
    return !bus.abort && (exp_q.size() == 0 || (exp_q.size() == 1 && bus.word_ready));
  endfunction

  // Advance one clock edge and update the model from the inputs seen at that edge.
  task automatic tick();
    logic beat, lr;
    logic [127:0] l;
    int off;
    beat = exp_valid() && bus.word_ready;
    lr   = exp_lr();
    l    = bus.line_in;
    off  = int'(bus.start_offset);
    @(posedge clk);
    if (reset || bus.abort) begin
      exp_q.delete();
    end else begin
      if (beat) void'(exp_q.pop_front());
      if (bus.load_valid && lr) begin
        for (int i = 0; i < 8; i++) begin
          int idx;
          idx = (off + i) % 8;
          exp_q.push_back('{o: 3'(idx), w: l[16*idx +: 16]});
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.line_in = '0; bus.start_offset = '0; bus.load_valid = 1'b0;
    bus.abort = 1'b0; bus.word_ready = 1'b0;
    tick();
    reset = 1'b0;
    #2;
    total++; if (bus.word_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.word_valid); end
    total++; if (bus.word_out !== 16'h0) begin bad++; $display("FAIL reset_word got=%h want=0000", bus.word_out); end
    total++; if (bus.word_offset !== 3'd0) begin bad++; $display("FAIL reset_offset got=%0d want=0", bus.word_offset); end
    total++; if (bus.word_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", bus.word_last); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.load_ready !== 1'b1) begin bad++; $display("FAIL reset_load_ready got=%b want=1", bus.load_ready); end
  endtask

  task automatic test_stream(input int off, input string name);
    bus.line_in = line_a; bus.start_offset = 3'(off); bus.load_valid = 1'b1; bus.word_ready = 1'b1;
    #2;
    total++; if (bus.load_ready !== 1'b1) begin bad++; $display("FAIL %s_load_ready got=%b want=1", name, bus.load_ready); end
    tick();
    bus.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] eo;
      eo = 3'((off + i) % 8);
      #2;
      total++;
      if ({bus.word_valid, bus.word_last, bus.word_offset, bus.word_out} !==
          {1'b1, (i == 7), eo, 16'hC0D0 + 16'(eo)}) begin
        bad++;
        $display("FAIL %s_beat%0d got v=%b l=%b o=%0d w=%h want v=1 l=%b o=%0d w=%h", name, i,
                 bus.word_valid, bus.word_last, bus.word_offset, bus.word_out, (i == 7), eo,
                 16'hC0D0 + 16'(eo));
      end
      tick();
    end
    #2;
    total++; if ({bus.busy, bus.word_valid} !== 2'b00) begin bad++; $display("FAIL %s_idle got busy=%b v=%b want 0 0", name, bus.busy, bus.word_valid); end
  endtask

  task automatic test_backpressure();
    int beats = 0;
    bus.line_in = line_a; bus.start_offset = 3'd0; bus.load_valid = 1'b1; bus.word_ready = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      bus.word_ready = !(c >= 2 && c <= 4);
      #2;
      total++;
      if (bus.word_valid !== 1'b1 || exp_q.size() == 0 || bus.word_out !== exp_q[0].w ||
          bus.word_last !== (c == 11)) begin
        bad++;
        $display("FAIL bp_cycle%0d got v=%b w=%h l=%b want v=1 w=%h l=%b", c, bus.word_valid,
                 bus.word_out, bus.word_last, (exp_q.size() > 0) ? exp_q[0].w : 16'hxxxx, (c == 11));
      end
      if (c >= 2 && c <= 4) begin
        total++; if (bus.word_out !== 16'hC0D1) begin bad++; $display("FAIL bp_hold%0d got=%h want=c0d1", c, bus.word_out); end
      end
      if (bus.word_valid && bus.word_ready) beats++;
      tick();
    end
    bus.word_ready = 1'b1;
    #2;
    total++; if (beats != 8 || bus.word_valid !== 1'b0) begin bad++; $display("FAIL bp_done got beats=%0d v=%b want 8 0", beats, bus.word_valid); end
  endtask

  task automatic test_back_to_back();
    bus.line_in = line_a; bus.start_offset = 3'd0; bus.load_valid = 1'b1; bus.word_ready = 1'b1;
    for (int c = 0; c <= 17; c++) begin
      logic lr_want;
      lr_want = (c == 0 || c == 8 || c == 16 || c == 17);
      #2;
      total++; if (bus.load_ready !== lr_want || bus.load_ready !== exp_lr()) begin bad++; $display("FAIL b2b_load_ready c=%0d got=%b want=%b", c, bus.load_ready, lr_want); end
      if (c >= 1 && c <= 16) begin
        total++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== exp_q[0].w) begin
          bad++; $display("FAIL b2b_word c=%0d got v=%b w=%h want v=1 w=%h", c, bus.word_valid, bus.word_out, exp_q[0].w);
        end
      end
      if (c == 9) begin
        total++; if (bus.word_out !== 16'h5A03) begin bad++; $display("FAIL b2b_nogap got=%h want=5a03", bus.word_out); end
      end
      tick();
      if (c == 0) begin bus.line_in = line_b; bus.start_offset = 3'd3; end
      if (c == 8) bus.load_valid = 1'b0;
    end
  endtask

  task automatic test_abort();
    int off;
    bus.line_in = line_a; bus.start_offset = 3'd0; bus.load_valid = 1'b1; bus.word_ready = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    tick(); tick();
    bus.abort = 1'b1; bus.load_valid = 1'b1; bus.line_in = line_b; bus.start_offset = 3'd3;
    #2;
    total++; if (bus.load_ready !== 1'b0) begin bad++; $display("FAIL abort_load_ready got=%b want=0", bus.load_ready); end
    total++; if (bus.word_out !== 16'hC0D2) begin bad++; $display("FAIL abort_word got=%h want=c0d2", bus.word_out); end
    tick();
    bus.abort = 1'b0; bus.load_valid = 1'b0;
    #2;
    total++; if ({bus.word_valid, bus.busy, bus.load_ready} !== 3'b001) begin bad++; $display("FAIL abort_idle got v=%b busy=%b lr=%b want 0 0 1", bus.word_valid, bus.busy, bus.load_ready); end
    off = $urandom_range(0, 7);
    bus.start_offset = 3'(off); bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] eo;
      eo = 3'((off + i) % 8);
      #2;
      total++;
      if ({bus.word_valid, bus.word_offset, bus.word_out} !== {1'b1, eo, 16'h5A00 + 16'(eo)}) begin
        bad++; $display("FAIL abort_reload%0d got v=%b o=%0d w=%h want v=1 o=%0d w=%h", i, bus.word_valid, bus.word_offset, bus.word_out, eo, 16'h5A00 + 16'(eo));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bus.line_in = line_a; bus.start_offset = 3'd2; bus.load_valid = 1'b1; bus.word_ready = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    total++;
    if ({bus.word_valid, bus.word_last, bus.busy, bus.load_ready, bus.word_offset, bus.word_out} !==
        {4'b0001, 3'd0, 16'h0}) begin
      bad++; $display("FAIL reset_mid got v=%b l=%b busy=%b lr=%b o=%0d w=%h want 0 0 0 1 0 0000",
                      bus.word_valid, bus.word_last, bus.busy, bus.load_ready, bus.word_offset, bus.word_out);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.line_in      = {$urandom, $urandom, $urandom, $urandom};
      bus.start_offset = 3'($urandom_range(0, 7));
      bus.load_valid   = ($urandom % 3) != 0;
      bus.word_ready   = ($urandom % 4) != 0;
      bus.abort        = ($urandom % 40) == 0;
      #2;
      total++;
      if ({bus.word_valid, bus.word_last, bus.busy, bus.load_ready} !==
          {exp_valid(), exp_last(), exp_valid(), exp_lr()}) begin
        bad++; $display("FAIL rand_ctrl c=%0d got v=%b l=%b busy=%b lr=%b want %b %b %b %b", c,
                        bus.word_valid, bus.word_last, bus.busy, bus.load_ready,
                        exp_valid(), exp_last(), exp_valid(), exp_lr());
      end
      if (exp_valid()) begin
        total++;
        if ({bus.word_offset, bus.word_out} !== exp_q[0]) begin
          bad++; $display("FAIL rand_word c=%0d got o=%0d w=%h want o=%0d w=%h", c,
                          bus.word_offset, bus.word_out, exp_q[0].o, exp_q[0].w);
        end
      end
      tick();
    end
    bus.abort = 1'b0; bus.load_valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      line_a[16*k +: 16] = 16'hC0D0 + 16'(k);
      line_b[16*k +: 16] = 16'h5A00 + 16'(k);
    end
    #1;
    test_reset();
    test_stream(0, "basic");
    test_stream(5, "wrap");
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_reader.md
# line_reader

Streams a 128-bit cache line out as eight 16-bit words over a valid/ready handshake. The first word is the requested (critical) offset, and the order wraps modulo 8. It sits on the cache read/writeback side, between the line array and a word-wide consumer (CPU fill return or word-wide memory writeback). It is the read-direction counterpart of the cache's word-into-line merge logic.

## Interface
- Parameters: none. Line geometry is fixed by `lc3b_types`: 8 words/line, 16 bits/word.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `line_in` in `lc3b_c_line` (128): line to stream; word k occupies bits [16k+15:16k].
- `start_offset` in `lc3b_c_offset` (3): first word to emit.
- `load_valid` in 1: `line_in`/`start_offset` are valid.
- `load_ready` out 1: block can accept a line this cycle.
- `abort` in 1: drop the current stream.
- `word_out` out `lc3b_word` (16): current word.
- `word_offset` out `lc3b_c_offset` (3): index of `word_out` within the line.
- `word_valid` out 1: `word_out` is valid.
- `word_ready` in 1: consumer accepts `word_out`.
- `word_last` out 1: current beat is the 8th of the line.
- `busy` out 1: state is SEND.

## Operation
- Registers:
  - `line_q` (128)
  - `ptr_q` (3)
  - `cnt_q` (3, beats issued)
  - `state_q` ∈ {IDLE, SEND}
- Definitions:
  - load = `load_valid && load_ready`
  - beat = `word_valid && word_ready`
- Output decode (from state only, except `load_ready`):
  - `word_valid` = (state==SEND)
  - `word_out` = `line_q[16*ptr_q +: 16]`
  - `word_offset` = `ptr_q`
  - `word_last` = SEND && `cnt_q`==7
  - `busy` = SEND
- `load_ready` = !`abort` && (IDLE || (SEND && `cnt_q`==7 && `word_ready`)). This is a combinational path from `word_ready` and `abort` to `load_ready`; it enables back-to-back lines with no bubble.
- IDLE:
  - On load: capture `line_q`, set `ptr_q`=`start_offset`, `cnt_q`=0, go to SEND.
  - Otherwise: hold.
- SEND, beat with `cnt_q`<7: `ptr_q`+=1 (wraps 7→0), `cnt_q`+=1.
- SEND, beat with `cnt_q`==7:
  - If load in the same cycle: reload registers as in IDLE and stay in SEND.
  - Otherwise: go to IDLE.
- SEND, no beat: hold everything. `word_out` stays stable while `word_valid` is high and `word_ready` is low.
- `abort` (any state):
  - Next state IDLE, `cnt_q`=0. Any beat that handshakes in the same cycle counts as delivered.
  - Any load in that cycle is blocked, because `load_ready` is 0.
  - `line_q` is not cleared.
- Priority: `reset` > `abort` > load/beat.

## Timing
- Reset values:
  - `state_q`=IDLE, `line_q`=0, `ptr_q`=0, `cnt_q`=0.
  - Hence `word_valid`=0, `word_out`=0, `word_offset`=0, `word_last`=0, `busy`=0.
  - `load_ready`=1 when `abort`=0.
- Latency: load at edge N → first word valid in cycle N+1.
- With `word_ready` held high, beats occur in cycles N+1..N+8 and `word_last` is high in cycle N+8.
- A line loaded at edge N+8 produces its first word in cycle N+9, so sustained throughput is 8 words per 8 cycles.
- Each stall cycle (`word_ready`=0) delays all later beats by one cycle.
- `reset` mid-stream: outputs reach reset values in the cycle after the edge and the remaining beats are lost.

## Structure
- Shared package `lc3b_types`:
  - Reuse `lc3b_word`, `lc3b_c_line`, `lc3b_c_offset`.
  - Add the constant `LC3B_C_WORDS = 8`.
  - Add the enum `lc3b_lr_state_t` {IDLE, SEND}.
- Sub-module `line_word_select`: combinational (line, offset) → word mux. It is reused by the cache hit read path.

## Test plan
1. Basic stream:
   - Stimulus: reset, then load a line whose word k = 16'hC0D0+k, `start_offset`=0, `word_ready`=1.
   - Response: `word_out` = C0D0..C0D7 in cycles 1..8; `word_last` only in cycle 8; IDLE in cycle 9.
2. Wrap-around:
   - Stimulus: same line, `start_offset`=5.
   - Response: `word_offset` sequence 5,6,7,0,1,2,3,4; words C0D5..C0D7, C0D0..C0D4.
3. Backpressure:
   - Stimulus: `word_ready`=0 for cycles 2–4.
   - Response: `word_out` holds C0D1 with `word_valid`=1 through the stall; all 8 words appear exactly once; `word_last` in cycle 11.
4. Back-to-back:
   - Stimulus: assert `load_valid` continuously with two lines (second line word k = 16'h5A00+k, offset 3).
   - Response: `load_ready`=1 only in IDLE and in the last-beat cycle; 5A03 follows C0D7 with no gap.
5. Abort:
   - Stimulus: assert `abort` at beat 3 together with `load_valid`.
   - Response: `load_ready`=0, next cycle IDLE, `word_valid`=0, no load taken; a following load streams normally from its own `start_offset`.
6. Reset mid-stream:
   - Stimulus: `reset`=1 at beat 4.
   - Response: next cycle all outputs at reset values and `load_ready`=1.
